// File: rtl/battle_pkg.sv
// battle_pkg: page, key, opcode and direction codes shared by the battle sequencer and its bench
package battle_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [3:0] {
        PG_MENU   = 4'd1,
        PG_DODGE  = 4'd9,
        PG_ATTACK = 4'd10,
        PG_ACTION = 4'd11,
        PG_WIN    = 4'd12,
        PG_LOSE   = 4'd13
    } page_t;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_HPY  = 4'd1,
        OP_DPY  = 4'd2,
        OP_MOV  = 4'd5
    } op_t;

    localparam logic [3:0] KEY_W     = 4'd1;
    localparam logic [3:0] KEY_A     = 4'd2;
    localparam logic [3:0] KEY_S     = 4'd3;
    localparam logic [3:0] KEY_D     = 4'd4;
    localparam logic [3:0] KEY_J     = 4'd5;
    localparam logic [3:0] KEY_K     = 4'd6;
    localparam logic [3:0] KEY_L     = 4'd7;
    localparam logic [3:0] KEY_SPACE = 4'd8;

    localparam logic [7:0] DIR_UP    = 8'd0;
    localparam logic [7:0] DIR_LEFT  = 8'd1;
    localparam logic [7:0] DIR_DOWN  = 8'd2;
    localparam logic [7:0] DIR_RIGHT = 8'd3;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/battle_sequencer_if.sv
// battle_sequencer_if: valid/ready player-instruction channel towards the player engine
interface battle_sequencer_if;
    import battle_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;

    modport master(output instr, output instr_valid, input instr_ready);
    modport slave(input instr, input instr_valid, output instr_ready);

endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle tick every CLK_HZ/TICK_HZ clocks, phase-aligned by restart
module tick_prescaler #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
    localparam int CW  = $clog2(DIV + 1);

    logic [CW-1:0] cnt;

    assign tick = cnt == CW'(DIV - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (restart || tick) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/battle_sequencer.sv
// battle_sequencer: battle page FSM with phase timer, monster HP and a one-deep
// player-instruction slot that merges or drops requests while the consumer stalls.
module battle_sequencer
    import battle_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 1,
    parameter int DODGE_TICKS  = 7,
    parameter int ACTION_TICKS = 7,
    parameter int ATTACK_TICKS = 3,
    parameter int HP_W         = 8,
    parameter int MON_HP_MAX   = 100,
    parameter int HEAL_AMT     = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         key,
    input  logic               is_death,
    input  logic               hit,
    input  logic               hit_heal,
    input  logic [HP_W-1:0]    hit_dmg,
    input  logic               atk_pass,
    input  logic [HP_W-1:0]    atk_dmg,
    output logic [3:0]         page,
    output logic [3:0]         ticks_left,
    output logic [HP_W-1:0]    mon_hp,
    battle_sequencer_if.master cmd,
    output logic               is_move
);
    localparam int         EW    = HP_W + 8;
    localparam logic [7:0] HEAL8 = 8'(HEAL_AMT);

    page_t           state, state_nxt;
    op_t             op_q, op_nxt, req_op;
    logic [7:0]      arg_q, arg_nxt, req_arg, dmg8;
    logic [EW-1:0]   dmg_ext;
    logic [HP_W-1:0] mon_nxt, atk_res;
    logic [3:0]      ticks_nxt;
    logic            tick, expiry, changed, req, pend, valid_nxt, move_nxt;

    tick_prescaler #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
        .clk(clk), .rst_n(rst_n), .restart(changed), .tick(tick)
    );

    assign page      = state;
    assign expiry    = tick && ticks_left == 4'd1;
    assign changed   = state_nxt != state;
    assign dmg_ext   = {8'b0, hit_dmg};
    assign dmg8      = dmg_ext > EW'(255) ? 8'hFF : dmg_ext[7:0];
    assign atk_res   = atk_dmg >= mon_hp ? '0 : mon_hp - atk_dmg;
    assign pend      = cmd.instr_valid && !cmd.instr_ready;
    assign cmd.instr = {op_q, arg_q, 4'b0};

    always_comb begin
        state_nxt = state;
        mon_nxt   = mon_hp;
        req       = 1'b0;
        req_op    = OP_HPY;
        req_arg   = HEAL8;
        case (state)
            PG_MENU:
                if (key == KEY_SPACE) begin
                    state_nxt = PG_DODGE;
                    mon_nxt   = HP_W'(MON_HP_MAX);
                end
            PG_DODGE:
                if (is_death)
                    state_nxt = PG_LOSE;
                else if (expiry)
                    state_nxt = PG_ACTION;
                else if (hit) begin
                    req     = 1'b1;
                    req_op  = hit_heal ? OP_HPY : OP_DPY;
                    req_arg = hit_heal ? HEAL8 : dmg8;
                end else if (key inside {KEY_W, KEY_A, KEY_S, KEY_D}) begin
                    req     = 1'b1;
                    req_op  = OP_MOV;
                    req_arg = key == KEY_W ? DIR_UP : key == KEY_A ? DIR_LEFT :
                              key == KEY_S ? DIR_DOWN : DIR_RIGHT;
                end
            PG_ACTION: begin
                // a player decision on the expiry cycle still wins over the timeout
                state_nxt = key == KEY_J ? PG_ATTACK :
                            (key == KEY_K || key == KEY_L || expiry) ? PG_DODGE : PG_ACTION;
                req       = key == KEY_K;
            end
            PG_ATTACK:
                if (atk_pass) begin
                    mon_nxt   = atk_res;
                    state_nxt = atk_res == '0 ? PG_WIN : PG_DODGE;
                end else if (expiry)
                    state_nxt = PG_DODGE;
            PG_WIN, PG_LOSE:
                if (key == KEY_SPACE)
                    state_nxt = PG_MENU;
            default:
                state_nxt = PG_MENU;
        endcase
    end

    assign ticks_nxt = changed ? (state_nxt == PG_DODGE  ? 4'(DODGE_TICKS)  :
                                  state_nxt == PG_ACTION ? 4'(ACTION_TICKS) :
                                  state_nxt == PG_ATTACK ? 4'(ATTACK_TICKS) : 4'd0) :
                       (tick && ticks_left != 4'd0) ? ticks_left - 4'd1 : ticks_left;

    always_comb begin
        op_nxt    = op_q;
        arg_nxt   = arg_q;
        valid_nxt = pend;
        move_nxt  = 1'b0;
        // a stalled MOV is stale once anything newer arrives, so it is always replaceable
        if (req && (!pend || op_q == OP_MOV)) begin
            op_nxt    = req_op;
            arg_nxt   = req_arg;
            valid_nxt = 1'b1;
            move_nxt  = req_op == OP_MOV;
        end else if (req && op_q == OP_DPY && req_op == OP_DPY)
            arg_nxt = sat_add8(arg_q, req_arg);
        if (changed && state_nxt inside {PG_MENU, PG_WIN, PG_LOSE})
            valid_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= PG_MENU;
        else
            state <= state_nxt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ticks_left      <= '0;
            mon_hp          <= '0;
            op_q            <= OP_NONE;
            arg_q           <= '0;
            cmd.instr_valid <= 1'b0;
            is_move         <= 1'b0;
        end else begin
            ticks_left      <= ticks_nxt;
            mon_hp          <= mon_nxt;
            op_q            <= op_nxt;
            arg_q           <= arg_nxt;
            cmd.instr_valid <= valid_nxt;
            is_move         <= move_nxt;
        end

endmodule

// File: tb/tb_battle_sequencer.sv
// tb_battle_sequencer: directed scenarios plus random play, checked against a
// cycle-count based model of the battle rules (tick every 10 cycles).
module tb_battle_sequencer;
    import battle_pkg::*;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [3:0] key = '0;
    logic       is_death = 1'b0, hit = 1'b0, hit_heal = 1'b0, atk_pass = 1'b0;
    logic [7:0] hit_dmg = '0, atk_dmg = '0;
    logic [3:0] page, ticks_left;
    logic [7:0] mon_hp;
    logic       is_move;
    int         tests = 0, fails = 0;
    int         m_page, m_cyc, m_hp, m_valid, m_op, m_arg, m_move;

    battle_sequencer_if bus();

    battle_sequencer #(.CLK_HZ(100), .TICK_HZ(10)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .is_death(is_death), .hit(hit),
        .hit_heal(hit_heal), .hit_dmg(hit_dmg), .atk_pass(atk_pass), .atk_dmg(atk_dmg),
        .page(page), .ticks_left(ticks_left), .mon_hp(mon_hp), .cmd(bus), .is_move(is_move)
    );

    always #5 clk = ~clk;

    function automatic int phase_len(input int p);
        return p == 9 ? 7 : p == 11 ? 7 : p == 10 ? 3 : 0;
    endfunction

    function automatic int exp_ticks();
        return phase_len(m_page) == 0 ? 0 : phase_len(m_page) - m_cyc / 10;
    endfunction

    function automatic logic [15:0] exp_instr();
        return 16'(m_op * 4096 + m_arg * 16);
    endfunction

    task automatic model_reset();
        m_page = 1; m_cyc = 0; m_hp = 0; m_valid = 0; m_op = 0; m_arg = 0; m_move = 0;
    endtask

    // one clock of the game rules, with the timer seen as cycles spent in the phase
    task automatic model_step();
        int np, nh, rop, rarg, len, k;
        bit expire, rq, pend;
        k      = int'(key);
        len    = phase_len(m_page);
        expire = len > 0 && m_cyc == len * 10 - 1;
        np = m_page; nh = m_hp; rq = 0; rop = 0; rarg = 0;
        case (m_page)
            1: if (k == 8) begin np = 9; nh = 100; end
            9: if (is_death) np = 13;
               else if (expire) np = 11;
               else if (hit) begin
                   rq = 1; rop = hit_heal ? 1 : 2; rarg = hit_heal ? 10 : int'(hit_dmg);
               end else if (k >= 1 && k <= 4) begin
                   rq = 1; rop = 5; rarg = k - 1;
               end
            11: if (k == 5) np = 10;
                else if (k == 6) begin np = 9; rq = 1; rop = 1; rarg = 10; end
                else if (k == 7 || expire) np = 9;
            10: if (atk_pass) begin
                    nh = m_hp - int'(atk_dmg);
                    if (nh < 0) nh = 0;
                    np = nh == 0 ? 12 : 9;
                end else if (expire) np = 9;
            default: if (k == 8) np = 1;
        endcase
        pend    = m_valid != 0 && !bus.instr_ready;
        m_move  = 0;
        m_valid = pend ? 1 : 0;
        if (rq) begin
            if (!pend || m_op == 5) begin
                m_op = rop; m_arg = rarg; m_valid = 1; m_move = rop == 5 ? 1 : 0;
            end else if (m_op == 2 && rop == 2)
                m_arg = m_arg + rarg > 255 ? 255 : m_arg + rarg;
        end
        if (np != m_page && (np == 1 || np == 12 || np == 13)) m_valid = 0;
        m_cyc  = np != m_page ? 0 : m_cyc + 1;
        m_page = np;
        m_hp   = nh;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        key = '0; hit = 1'b0; hit_heal = 1'b0; atk_pass = 1'b0; is_death = 1'b0;
    endtask

    task automatic wait_page(input int target, input int budget, output int n);
        n = 0;
        while (int'(page) != target && n < budget) begin
            step();
            n++;
        end
        tests++;
        if (int'(page) != target) begin
            fails++;
            $display("FAIL wait_page: page=%0d required=%0d after %0d cycles", page, target, n);
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        bus.instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests += 5;
        if (page !== 4'd1) begin fails++; $display("FAIL reset_page: got %0d want 1", page); end
        if (ticks_left !== 4'd0) begin fails++; $display("FAIL reset_ticks: got %0d want 0", ticks_left); end
        if (mon_hp !== 8'd0) begin fails++; $display("FAIL reset_hp: got %0d want 0", mon_hp); end
        if (bus.instr !== 16'h0 || bus.instr_valid !== 1'b0) begin
            fails++; $display("FAIL reset_instr: got %h/%b want 0000/0", bus.instr, bus.instr_valid);
        end
        if (is_move !== 1'b0) begin fails++; $display("FAIL reset_move: got %b want 0", is_move); end
        rst_n = 1'b1;
    endtask

    task automatic test_start();
        int n;
        key = KEY_SPACE;
        step();
        tests += 3;
        if (page !== 4'd9) begin fails++; $display("FAIL start_page: got %0d want 9", page); end
        if (mon_hp !== 8'd100) begin fails++; $display("FAIL start_hp: got %0d want 100", mon_hp); end
        if (ticks_left !== 4'd7) begin fails++; $display("FAIL start_ticks: got %0d want 7", ticks_left); end
        n = 0;
        while (page != 4'd11 && n < 100) begin
            step();
            n++;
            if (n == 10) begin
                tests++;
                if (ticks_left !== 4'd6) begin fails++; $display("FAIL dodge_tick: got %0d want 6", ticks_left); end
            end
        end
        tests += 2;
        if (n != 70) begin fails++; $display("FAIL dodge_len: got %0d cycles want 70", n); end
        if (page !== 4'd11 || ticks_left !== 4'd7) begin
            fails++; $display("FAIL action_entry: got page %0d ticks %0d want 11/7", page, ticks_left);
        end
        key = KEY_L;
        step();
        tests++;
        if (page !== 4'd9) begin fails++; $display("FAIL action_l: got %0d want 9", page); end
    endtask

    task automatic test_dpy_sat();
        bus.instr_ready = 1'b0;
        hit = 1'b1; hit_dmg = 8'd200;
        step();
        tests++;
        if (bus.instr !== 16'h2C80 || bus.instr_valid !== 1'b1) begin
            fails++; $display("FAIL dpy_load: got %h/%b want 2c80/1", bus.instr, bus.instr_valid);
        end
        hit = 1'b1; hit_dmg = 8'd100;
        step();
        tests++;
        if (bus.instr !== 16'h2FF0) begin fails++; $display("FAIL dpy_sat: got %h want 2ff0", bus.instr); end
        bus.instr_ready = 1'b1;
        step();
        tests++;
        if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL dpy_accept: got %b want 0", bus.instr_valid); end
    endtask

    task automatic test_heal_overwrite();
        bus.instr_ready = 1'b0;
        key = KEY_W;
        step();
        tests++;
        if (bus.instr !== 16'h5000 || is_move !== 1'b1) begin
            fails++; $display("FAIL mov_up: got %h move %b want 5000/1", bus.instr, is_move);
        end
        hit = 1'b1; hit_heal = 1'b1;
        step();
        tests++;
        if (bus.instr !== 16'h10A0 || is_move !== 1'b0) begin
            fails++; $display("FAIL heal_over_mov: got %h move %b want 10a0/0", bus.instr, is_move);
        end
        key = KEY_D;
        step();
        tests++;
        if (bus.instr !== 16'h10A0 || is_move !== 1'b0 || bus.instr_valid !== 1'b1) begin
            fails++; $display("FAIL mov_dropped: got %h move %b valid %b want 10a0/0/1", bus.instr, is_move, bus.instr_valid);
        end
        bus.instr_ready = 1'b1;
        step();
        tests++;
        if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL heal_accept: got %b want 0", bus.instr_valid); end
    endtask

    task automatic test_attack_win();
        int n;
        wait_page(11, 100, n);
        key = KEY_J;
        step();
        tests++;
        if (page !== 4'd10 || ticks_left !== 4'd3) begin
            fails++; $display("FAIL attack_entry: got page %0d ticks %0d want 10/3", page, ticks_left);
        end
        atk_pass = 1'b1; atk_dmg = 8'd60;
        step();
        tests++;
        if (mon_hp !== 8'd40 || page !== 4'd9) begin
            fails++; $display("FAIL atk_first: got hp %0d page %0d want 40/9", mon_hp, page);
        end
        bus.instr_ready = 1'b0;
        hit = 1'b1; hit_dmg = 8'd5;
        step();
        wait_page(11, 100, n);
        key = KEY_J;
        step();
        tests++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h2050) begin
            fails++; $display("FAIL instr_kept: got %h/%b want 2050/1", bus.instr, bus.instr_valid);
        end
        atk_pass = 1'b1; atk_dmg = 8'd60;
        step();
        tests++;
        if (mon_hp !== 8'd0 || page !== 4'd12 || bus.instr_valid !== 1'b0) begin
            fails++; $display("FAIL atk_win: got hp %0d page %0d valid %b want 0/12/0", mon_hp, page, bus.instr_valid);
        end
        key = KEY_SPACE;
        step();
        tests++;
        if (page !== 4'd1) begin fails++; $display("FAIL win_menu: got %0d want 1", page); end
        bus.instr_ready = 1'b1;
    endtask

    task automatic test_death_expiry();
        int n;
        key = KEY_SPACE;
        step();
        repeat (69) step();
        tests++;
        if (ticks_left !== 4'd1 || page !== 4'd9) begin
            fails++; $display("FAIL pre_expiry: got ticks %0d page %0d want 1/9", ticks_left, page);
        end
        is_death = 1'b1;
        step();
        tests++;
        if (page !== 4'd13) begin fails++; $display("FAIL death_wins: got %0d want 13", page); end
        key = KEY_SPACE;
        step();
        key = KEY_SPACE;
        step();
        wait_page(11, 100, n);
        key = KEY_J;
        step();
        repeat (29) step();
        tests++;
        if (page !== 4'd10 || ticks_left !== 4'd1) begin
            fails++; $display("FAIL attack_hold: got page %0d ticks %0d want 10/1", page, ticks_left);
        end
        step();
        tests++;
        if (page !== 4'd9 || mon_hp !== 8'd100) begin
            fails++; $display("FAIL attack_timeout: got page %0d hp %0d want 9/100", page, mon_hp);
        end
    endtask

    task automatic test_reset_mid_dodge();
        bus.instr_ready = 1'b0;
        key = KEY_A;
        step();
        tests++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h5010) begin
            fails++; $display("FAIL mov_left: got %h/%b want 5010/1", bus.instr, bus.instr_valid);
        end
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        tests++;
        if (page !== 4'd1 || bus.instr_valid !== 1'b0 || mon_hp !== 8'd0) begin
            fails++; $display("FAIL mid_reset: got page %0d valid %b hp %0d want 1/0/0", page, bus.instr_valid, mon_hp);
        end
        rst_n = 1'b1;
        bus.instr_ready = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            key             = $urandom_range(0, 99) < 70 ? 4'd0 : 4'($urandom_range(1, 8));
            is_death        = $urandom_range(0, 299) == 0;
            hit             = $urandom_range(0, 7) == 0;
            hit_heal        = $urandom_range(0, 3) == 0;
            hit_dmg         = 8'($urandom_range(0, 255));
            atk_pass        = $urandom_range(0, 5) == 0;
            atk_dmg         = 8'($urandom_range(0, 80));
            bus.instr_ready = $urandom_range(0, 2) != 0;
            step();
            tests += 6;
            if (page !== 4'(m_page)) begin fails++; $display("FAIL rnd_page @%0d: got %0d want %0d", i, page, m_page); end
            if (ticks_left !== 4'(exp_ticks())) begin fails++; $display("FAIL rnd_ticks @%0d: got %0d want %0d", i, ticks_left, exp_ticks()); end
            if (mon_hp !== 8'(m_hp)) begin fails++; $display("FAIL rnd_hp @%0d: got %0d want %0d", i, mon_hp, m_hp); end
            if (bus.instr_valid !== 1'(m_valid)) begin fails++; $display("FAIL rnd_valid @%0d: got %b want %0d", i, bus.instr_valid, m_valid); end
            if (bus.instr !== exp_instr()) begin fails++; $display("FAIL rnd_instr @%0d: got %h want %h", i, bus.instr, exp_instr()); end
            if (is_move !== 1'(m_move)) begin fails++; $display("FAIL rnd_move @%0d: got %b want %0d", i, is_move, m_move); end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_dpy_sat();
        test_heal_overwrite();
        test_attack_win();
        test_death_expiry();
        test_reset_mid_dodge();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
